// File: rtl/trap_gen.sv
// ---------------------------------------------------------------------------
// trap_gen
//
// Trapezoid / triangle waveform generator. The unsigned output ramps up to a
// programmable peak, holds there, ramps back down to zero and holds again.
// New settings arrive through a one-deep valid/ready shadow register and are
// promoted to the active set only on a period boundary (LOW exit) or while
// idle, so a period in progress is never disturbed.
//
// Ports
//   clk          rising-edge clock
//   res          synchronous active-high reset (priority over everything)
//   en           run enable; 0 freezes state, counter and d_out
//   cfg_valid    configuration offer
//   cfg_ready    shadow register empty; transfer on cfg_valid && cfg_ready
//   cfg_peak     ramp peak
//   cfg_step     per-cycle increment/decrement (0 behaves as 1)
//   cfg_hold_hi  top hold length minus one
//   cfg_hold_lo  bottom hold length minus one
//   cfg_oneshot  1: run a single period then park in IDLE
//   d_out        registered waveform sample
//   phase        current state (IDLE=0 RISE=1 HIGH=2 FALL=3 LOW=4)
//   busy         registered phase != IDLE
//   period_done  one-cycle pulse in the first cycle after each period
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | d_out=0; promotes a pending shadow, then starts a period
// RISE   | d_out climbs by step, saturating at peak
// HIGH   | d_out=peak for hold_hi+1 cycles
// FALL   | d_out drops by step, saturating at zero
// LOW    | d_out=0 for hold_lo+1 cycles; period boundary on exit
// ---------------------------------------------------------------------------
module trap_gen #(
    parameter int DW       = 9,
    parameter int CW       = 8,
    parameter int RST_PEAK = 299,
    parameter int RST_HOLD = 200
) (
    input  logic          clk,
    input  logic          res,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_peak,
    input  logic [DW-1:0] cfg_step,
    input  logic [CW-1:0] cfg_hold_hi,
    input  logic [CW-1:0] cfg_hold_lo,
    input  logic          cfg_oneshot,
    output logic [DW-1:0] d_out,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          period_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RISE = 3'd1,
        S_HIGH = 3'd2,
        S_FALL = 3'd3,
        S_LOW  = 3'd4
    } state_t;

    state_t        state_q, state_d;

    // datapath registers
    logic [DW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;

    // active configuration
    logic [DW-1:0] act_peak;
    logic [DW-1:0] act_step;
    logic [CW-1:0] act_hold_hi;
    logic [CW-1:0] act_hold_lo;
    logic          act_oneshot;

    // shadow configuration; ready_q doubles as the "shadow empty" flag
    logic [DW-1:0] shd_peak;
    logic [DW-1:0] shd_step;
    logic [CW-1:0] shd_hold_hi;
    logic [CW-1:0] shd_hold_lo;
    logic          shd_oneshot;
    logic          ready_q;

    // derived conditions
    logic [DW-1:0] step_eff;
    logic [DW:0]   rise_sum;
    logic          rise_top;
    logic          fall_bottom;
    logic          hi_done;
    logic          lo_done;
    logic          pending;
    logic          xfer;
    logic          apply;

    // One extra bit on the rising sum so a large step cannot wrap past peak.
    assign step_eff    = (act_step == '0) ? DW'(1) : act_step;
    assign rise_sum    = {1'b0, d_q} + {1'b0, step_eff};
    assign rise_top    = (rise_sum >= {1'b0, act_peak});
    assign fall_bottom = (d_q <= step_eff);
    assign hi_done     = (cnt_q == act_hold_hi);
    assign lo_done     = (cnt_q == act_hold_lo);

    assign pending = ~ready_q;
    assign xfer    = cfg_valid & ready_q;
    // Promotion points: any enabled IDLE cycle, or the edge leaving LOW.
    assign apply   = en & pending &
                     ((state_q == S_IDLE) || ((state_q == S_LOW) && lo_done));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    // A pending shadow is promoted first; the ramp starts on
                    // the following enabled cycle with the new settings.
                    if (!pending && !halted_q) begin
                        state_d = S_RISE;
                    end
                end
                S_RISE: begin
                    if (rise_top) begin
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (hi_done) begin
                        state_d = S_FALL;
                    end
                end
                S_FALL: begin
                    if (fall_bottom) begin
                        state_d = S_LOW;
                    end
                end
                S_LOW: begin
                    // Decision uses the oneshot bit of the period just ending.
                    if (lo_done) begin
                        state_d = act_oneshot ? S_IDLE : S_RISE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        d_d      = d_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        halted_d = halted_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    d_d   = '0;
                    cnt_d = '0;
                    // New settings re-arm a generator parked after a oneshot.
                    if (pending) begin
                        halted_d = 1'b0;
                    end
                end
                S_RISE: begin
                    d_d   = rise_top ? act_peak : rise_sum[DW-1:0];
                    cnt_d = '0;
                end
                S_HIGH: begin
                    d_d   = act_peak;
                    cnt_d = hi_done ? '0 : cnt_q + CW'(1);
                end
                S_FALL: begin
                    d_d   = fall_bottom ? '0 : d_q - step_eff;
                    cnt_d = '0;
                end
                S_LOW: begin
                    d_d = '0;
                    if (lo_done) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        // Settings arriving at the boundary start a fresh run
                        // rather than being parked behind the oneshot stop.
                        halted_d = act_oneshot & ~pending;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    d_d   = '0;
                    cnt_d = '0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // -----------------------------------------------------------------------
    // Datapath and configuration registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            d_q         <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            act_peak    <= DW'(RST_PEAK);
            act_step    <= DW'(1);
            act_hold_hi <= CW'(RST_HOLD);
            act_hold_lo <= CW'(RST_HOLD);
            act_oneshot <= 1'b0;
            shd_peak    <= '0;
            shd_step    <= '0;
            shd_hold_hi <= '0;
            shd_hold_lo <= '0;
            shd_oneshot <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            // apply needs a full shadow and xfer an empty one, so the two
            // branches are mutually exclusive.
            if (apply) begin
                act_peak    <= shd_peak;
                act_step    <= shd_step;
                act_hold_hi <= shd_hold_hi;
                act_hold_lo <= shd_hold_lo;
                act_oneshot <= shd_oneshot;
                ready_q     <= 1'b1;
            end else if (xfer) begin
                shd_peak    <= cfg_peak;
                shd_step    <= cfg_step;
                shd_hold_hi <= cfg_hold_hi;
                shd_hold_lo <= cfg_hold_lo;
                shd_oneshot <= cfg_oneshot;
                ready_q     <= 1'b0;
            end
        end
    end

    assign d_out       = d_q;
    assign phase       = state_q;
    assign busy        = busy_q;
    assign period_done = done_q;
    assign cfg_ready   = ready_q;

endmodule

// File: tb/tb_trap_gen.sv
module tb_trap_gen;

    localparam int DW = 9;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          res, en, cfg_valid, cfg_ready, cfg_oneshot;
    logic [DW-1:0] cfg_peak, cfg_step, d_out;
    logic [CW-1:0] cfg_hold_hi, cfg_hold_lo;
    logic [2:0]    phase;
    logic          busy, period_done;

    int checks   = 0;
    int failures = 0;

    // packed sample: {phase, busy, period_done, d_out}
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];

    always #5 clk = ~clk;

    trap_gen #(.DW(DW), .CW(CW), .RST_PEAK(299), .RST_HOLD(200)) dut (
        .clk(clk), .res(res), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_peak(cfg_peak), .cfg_step(cfg_step),
        .cfg_hold_hi(cfg_hold_hi), .cfg_hold_lo(cfg_hold_lo),
        .cfg_oneshot(cfg_oneshot),
        .d_out(d_out), .phase(phase), .busy(busy), .period_done(period_done)
    );

    // ---------------- reference model ----------------
    function automatic logic [13:0] pk(input logic [2:0] ph, input logic dn, input int d);
        logic [DW-1:0] dv;
        dv = d[DW-1:0];
        return {ph, (ph != 3'd0), dn, dv};
    endfunction

    function automatic int period_len(input int peak, input int step, input int hh, input int hl);
        int s, n;
        s = (step == 0) ? 1 : step;
        n = (peak + s - 1) / s;
        if (n < 1) n = 1;
        return 2 * n + hh + hl + 2;
    endfunction

    // Per-cycle view of one period: values seen during each cycle.
    task automatic model_period(input int peak, input int step, input int hh,
                                input int hl, input bit first);
        int s, n, v;
        s = (step == 0) ? 1 : step;
        n = (peak + s - 1) / s;
        if (n < 1) n = 1;
        for (int k = 0; k < n; k++) begin
            v = (k * s < peak) ? k * s : peak;
            exp_q.push_back(pk(3'd1, (k == 0) && !first, v));
        end
        for (int k = 0; k <= hh; k++) exp_q.push_back(pk(3'd2, 1'b0, peak));
        for (int k = 0; k < n; k++) begin
            v = (peak - k * s > 0) ? peak - k * s : 0;
            exp_q.push_back(pk(3'd3, 1'b0, v));
        end
        for (int k = 0; k <= hl; k++) exp_q.push_back(pk(3'd4, 1'b0, 0));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic collect(input int n);
        repeat (n) begin
            @(negedge clk);
            obs_q.push_back({phase, busy, period_done, d_out});
        end
    endtask

    task automatic start_default();
        res = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0; en = 1'b1;
        exp_q.delete(); obs_q.delete();
    endtask

    // Leaves the bench at the negedge of the IDLE cycle with cfg applied.
    task automatic start_cfg(input int peak, input int step, input int hh,
                             input int hl, input bit os);
        res = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        cfg_valid = 1'b1; cfg_peak = peak[DW-1:0]; cfg_step = step[DW-1:0];
        cfg_hold_hi = hh[CW-1:0]; cfg_hold_lo = hl[CW-1:0]; cfg_oneshot = os;
        @(negedge clk);
        cfg_valid = 1'b0; en = 1'b1;
        @(negedge clk);
        exp_q.delete(); obs_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad, first;
        res = 1'b1; en = 1'b1;
        cfg_valid = 1'b1; cfg_peak = 9'd5; cfg_step = 9'd4;
        cfg_hold_hi = 8'd0; cfg_hold_lo = 8'd0; cfg_oneshot = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (d_out !== 9'd0) begin failures++; $display("FAIL reset_d_out: got %0d want 0", d_out); end
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase: got %0d want 0", phase); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (period_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", period_done); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        res = 1'b0; cfg_valid = 1'b0;
        exp_q.delete(); obs_q.delete();
        collect(4);
        model_period(299, 1, 200, 200, 1'b1);
        bad = 0; first = 0;
        for (int i = 0; i < 4; i++)
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL reset_first_ramp: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
    endtask

    task automatic test_defaults();
        int bad, first;
        start_default();
        model_period(299, 1, 200, 200, 1'b1);
        model_period(299, 1, 200, 200, 1'b0);
        exp_q.push_back(pk(3'd1, 1'b1, 0));
        collect(exp_q.size());
        bad = 0; first = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wave_defaults: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
        checks++;
        if (obs_q[1000][9] !== 1'b1 || obs_q[2000][9] !== 1'b1) begin
            failures++; $display("FAIL done_spacing: got %b/%b want 1/1", obs_q[1000][9], obs_q[2000][9]);
        end
    endtask

    task automatic test_small_cfg();
        int bad, first;
        start_cfg(20, 7, 0, 1, 1'b0);
        for (int p = 0; p < 3; p++) model_period(20, 7, 0, 1, p == 0);
        collect(exp_q.size());
        bad = 0; first = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wave_small_cfg: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
    endtask

    task automatic test_random_cfg();
        int bad, first, pkv, stv, hh, hl;
        for (int r = 0; r < 5; r++) begin
            pkv = (r == 0) ? 0 : int'($urandom_range(1, 300));
            if (r == 1)      stv = pkv + int'($urandom_range(1, 50));
            else if (r == 2) stv = 0;
            else             stv = int'($urandom_range(1, 40));
            hh = int'($urandom_range(0, 15));
            hl = int'($urandom_range(0, 15));
            start_cfg(pkv, stv, hh, hl, 1'b0);
            for (int p = 0; p < 3; p++) model_period(pkv, stv, hh, hl, p == 0);
            collect(exp_q.size());
            bad = 0; first = 0;
            for (int i = 0; i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL wave_random peak=%0d step=%0d hh=%0d hl=%0d: %0d differ, idx %0d got %h want %h",
                         pkv, stv, hh, hl, bad, first, obs_q[first], exp_q[first]);
            end
        end
    endtask

    task automatic test_midperiod_cfg();
        int bad, first, rbad, rfirst, b1, b2, n;
        logic last_rdy, b_offered, rdy_exp;
        logic rdy_obs[$];
        start_default();
        model_period(299, 1, 200, 200, 1'b1);
        model_period(10, 3, 2, 3, 1'b0);
        model_period(6, 6, 0, 0, 1'b0);
        model_period(6, 6, 0, 0, 1'b0);
        b1 = period_len(299, 1, 200, 200);
        b2 = b1 + period_len(10, 3, 2, 3);
        n = exp_q.size();
        last_rdy = 1'b0; b_offered = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            obs_q.push_back({phase, busy, period_done, d_out});
            rdy_obs.push_back(cfg_ready);
            if (cfg_valid && last_rdy) cfg_valid = 1'b0;
            if (c == 400) begin
                cfg_valid = 1'b1; cfg_peak = 9'd10; cfg_step = 9'd3;
                cfg_hold_hi = 8'd2; cfg_hold_lo = 8'd3; cfg_oneshot = 1'b0;
            end else if (c >= 500 && !b_offered && !cfg_valid) begin
                b_offered = 1'b1;
                cfg_valid = 1'b1; cfg_peak = 9'd6; cfg_step = 9'd6;
                cfg_hold_hi = 8'd0; cfg_hold_lo = 8'd0; cfg_oneshot = 1'b0;
            end
            last_rdy = cfg_ready;
        end
        cfg_valid = 1'b0;
        bad = 0; first = 0; rbad = 0; rfirst = 0;
        for (int i = 0; i < n; i++) begin
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
            rdy_exp = (i <= 400) || (i == b1) || (i >= b2);
            if (rdy_obs[i] !== rdy_exp) begin if (rbad == 0) rfirst = i; rbad++; end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wave_midperiod_cfg: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
        checks++;
        if (rbad != 0) begin failures++; $display("FAIL cfg_ready_stall: %0d differ, idx %0d got %b want %b", rbad, rfirst, rdy_obs[rfirst], !rdy_obs[rfirst]); end
    endtask

    task automatic test_oneshot();
        int bad, first, pulses;
        start_cfg(4, 1, 0, 0, 1'b1);
        model_period(4, 1, 0, 0, 1'b1);
        exp_q.push_back(pk(3'd0, 1'b1, 0));
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(3'd0, 1'b0, 0));
        collect(exp_q.size());
        bad = 0; first = 0; pulses = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
            if (obs_q[i][9] === 1'b1) pulses++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wave_oneshot: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL oneshot_done_count: got %0d want 1", pulses); end
    endtask

    task automatic test_en_freeze();
        int bad, first;
        logic [13:0] base[$];
        start_default();
        model_period(299, 1, 200, 200, 1'b1);
        base = exp_q;
        exp_q.delete();
        for (int i = 0; i <= 700; i++) exp_q.push_back(base[i]);
        for (int i = 0; i < 5; i++) exp_q.push_back(base[700]);
        for (int i = 701; i < base.size(); i++) exp_q.push_back(base[i]);
        exp_q.push_back(pk(3'd1, 1'b1, 0));
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            obs_q.push_back({phase, busy, period_done, d_out});
            if (c == 700) en = 1'b0;
            if (c == 705) en = 1'b1;
        end
        bad = 0; first = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wave_en_freeze: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
    endtask

    task automatic test_reset_midrise();
        int bad, first;
        start_cfg(400, 3, 10, 10, 1'b0);
        model_period(400, 3, 10, 10, 1'b1);
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            obs_q.push_back({phase, busy, period_done, d_out});
            if (c == 20) begin
                cfg_valid = 1'b1; cfg_peak = 9'd50; cfg_step = 9'd5;
                cfg_hold_hi = 8'd1; cfg_hold_lo = 8'd1; cfg_oneshot = 1'b1;
            end
            if (c == 21) cfg_valid = 1'b0;
        end
        bad = 0; first = 0;
        for (int i = 0; i <= 50; i++)
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wave_pre_reset: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
        checks++; if (d_out !== 9'd150) begin failures++; $display("FAIL midrise_value: got %0d want 150", d_out); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL midrise_shadow_full: got %b want 0", cfg_ready); end
        res = 1'b1;
        @(negedge clk);
        checks++; if (d_out !== 9'd0) begin failures++; $display("FAIL midrise_reset_d_out: got %0d want 0", d_out); end
        checks++; if (phase !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL midrise_reset_phase: got %0d/%b want 0/0", phase, busy); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL midrise_reset_cfg_ready: got %b want 1", cfg_ready); end
        res = 1'b0;
        exp_q.delete(); obs_q.delete();
        model_period(299, 1, 200, 200, 1'b1);
        exp_q.push_back(pk(3'd1, 1'b1, 0));
        collect(exp_q.size());
        bad = 0; first = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin if (bad == 0) first = i; bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wave_post_reset_defaults: %0d differ, idx %0d got %h want %h", bad, first, obs_q[first], exp_q[first]); end
    endtask

    initial begin
        res = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_peak = '0; cfg_step = '0; cfg_hold_hi = '0; cfg_hold_lo = '0; cfg_oneshot = 1'b0;
        test_reset();
        test_defaults();
        test_small_cfg();
        test_random_cfg();
        test_midperiod_cfg();
        test_oneshot();
        test_en_freeze();
        test_reset_midrise();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
